// File: rtl/sap2_bus_loader.sv
// sap2_bus_loader: receive side of the SAP-2 16-bit internal bus.
// Latches bus contents into the register file on load strobes, runs the
// MAR/MDR memory handshake with an ack timeout, and keeps the program counter.
// Optional feature macro: SAP2_OUT_HANDSHAKE_EN (OUT port valid/ack handshake).
//
// Memory handshake (valid/ready): mem_req is the valid; mem_ack is the ready.
// While mem_req is high, mem_we, mem_addr and mem_wdata are held stable. The
// transfer completes on the first rising edge where mem_req and mem_ack are
// both high; mem_rdata is sampled on that same edge. mem_ack with no request
// outstanding carries no meaning and is ignored.
module sap2_bus_loader #(
    parameter logic [15:0] PC_RST      = 16'h0000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        nCLR,
    input  logic [15:0] bus_in,
    input  logic        La,
    input  logic        Lb,
    input  logic        Lc,
    input  logic        Ltmp,
    input  logic        Li,
    input  logic        Lo,
    input  logic        Lmar,
    input  logic        Lmarc,
    input  logic        Lpcl,
    input  logic        Lpcu,
    input  logic        Ip,
    input  logic        Lmdr,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        out_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        mem_err,
    output logic [7:0]  a,
    output logic [7:0]  b,
    output logic [7:0]  c,
    output logic [7:0]  tmp,
    output logic [7:0]  ir,
    output logic [7:0]  out_port,
    output logic        out_valid,
    output logic [15:0] pc,
    output logic [15:0] mar,
    output logic [7:0]  mdr,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    localparam int                CNT_W    = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             rd_done;
    logic             idle;

    logic [7:0]  a_q, a_d, b_q, b_d, c_q, c_d;
    logic [7:0]  tmp_q, tmp_d, ir_q, ir_d;
    logic [7:0]  out_q, out_d;
    logic        ov_q, ov_d;
    logic [15:0] pc_q, pc_d, mar_q, mar_d;
    logic [7:0]  mdr_q, mdr_d;

    assign idle = (state_q == S_IDLE);

    // Memory FSM: next state, ack/timeout counter and sticky error flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rd_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_wr) begin
                    state_d = S_WR;
                    cnt_d   = '0;
                end else if (mem_rd) begin
                    state_d = S_RD;
                    cnt_d   = '0;
                end
            end
            S_RD, S_WR: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                    rd_done = (state_q == S_RD);
                end else if (cnt_q == CNT_LAST) begin
                    // Memory never answered: abort without touching MDR.
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory FSM state register; reset drops any transaction immediately.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Register file next values; MAR/MDR are frozen while a transaction runs.
    always_comb begin
        a_d   = La   ? bus_in[7:0] : a_q;
        b_d   = Lb   ? bus_in[7:0] : b_q;
        c_d   = Lc   ? bus_in[7:0] : c_q;
        tmp_d = Ltmp ? bus_in[7:0] : tmp_q;
        ir_d  = Li   ? bus_in[7:0] : ir_q;

        // Explicit half loads beat the increment; only named halves change.
        pc_d = pc_q;
        if (Lpcl || Lpcu) begin
            if (Lpcl) pc_d[7:0]  = bus_in[7:0];
            if (Lpcu) pc_d[15:8] = bus_in[7:0];
        end else if (Ip) begin
            pc_d = pc_q + 16'd1;
        end

        mar_d = mar_q;
        mdr_d = mdr_q;
        if (idle) begin
            if (Lmar)       mar_d = bus_in;
            else if (Lmarc) mar_d = {mar_q[15:8], bus_in[7:0]};
            if (Lmdr)       mdr_d = bus_in[7:0];
        end
        if (rd_done) mdr_d = mem_rdata;

`ifdef SAP2_OUT_HANDSHAKE_EN
        // OUT holds until the consumer accepts; a load in the accept cycle
        // replaces the data and keeps valid asserted.
        out_d = out_q;
        ov_d  = ov_q;
        if (Lo && (!ov_q || out_ack)) begin
            out_d = bus_in[7:0];
            ov_d  = 1'b1;
        end else if (out_ack) begin
            ov_d = 1'b0;
        end
`else
        // No consumer handshake: valid is a one-cycle pulse after each load.
        out_d = Lo ? bus_in[7:0] : out_q;
        ov_d  = Lo;
`endif
    end

`ifndef SAP2_OUT_HANDSHAKE_EN
    logic unused_out_ack;
    assign unused_out_ack = out_ack;
`endif

    // Register file storage.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            tmp_q <= '0;
            ir_q  <= '0;
            out_q <= '0;
            ov_q  <= 1'b0;
            pc_q  <= PC_RST;
            mar_q <= '0;
            mdr_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            tmp_q <= tmp_d;
            ir_q  <= ir_d;
            out_q <= out_d;
            ov_q  <= ov_d;
            pc_q  <= pc_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
        end
    end

    assign mem_req   = !idle;
    assign busy      = !idle;
    assign mem_we    = (state_q == S_WR);
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
    assign mem_err   = err_q;
    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign tmp       = tmp_q;
    assign ir        = ir_q;
    assign out_port  = out_q;
    assign out_valid = ov_q;
    assign pc        = pc_q;
    assign mar       = mar_q;
    assign mdr       = mdr_q;
    assign dbg_state = state_q;

endmodule
